// File: rtl/cpu_trace_emitter.sv
// Serialises one CPU write-back record into a cpu_checker ASCII trace line,
// one character per clock: "^T@P: $G <= D#" or "^T@P: *A <= D#".
module cpu_trace_emitter #(
    parameter int UPPER_HEX = 0,
    parameter int IDLE_GAP  = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_kind,
    input  logic [13:0] in_time,
    input  logic [31:0] in_pc,
    input  logic [4:0]  in_grf,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_data,
    output logic [7:0]  char,
    output logic        char_valid,
    output logic        last,
    output logic        sat
);

    typedef enum logic [3:0] {
        S_IDLE, S_CONV, S_TIME, S_AT, S_PC, S_SEP, S_SIGIL,
        S_GRF, S_ADDR, S_ARROW, S_DATA, S_HASH, S_END
    } state_t;

    state_t      state;
    logic [2:0]  idx;
    logic [3:0]  cnt;
    logic [3:0]  gap;
    logic [29:0] dd;
    logic        kind_r;
    logic [31:0] pc_r;
    logic [4:0]  grf_r;
    logic [31:0] addr_r;
    logic [31:0] data_r;

    logic [15:0] bcd;
    logic [1:0]  t_lead;
    logic [3:0]  grf_tens;
    logic [3:0]  grf_ones;

    function automatic logic [29:0] dd_step(input logic [29:0] v);
        logic [29:0] a;
        a = v;
        for (int unsigned k = 0; k < 4; k++) begin
            if (a[14 + 4*k +: 4] >= 4'd5)
                a[14 + 4*k +: 4] = a[14 + 4*k +: 4] + 4'd3;
        end
        return {a[28:0], 1'b0};
    endfunction

    function automatic logic [7:0] dec_char(input logic [3:0] n);
        return 8'h30 + {4'h0, n};
    endfunction

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        if (n < 4'd10)
            return 8'h30 + {4'h0, n};
        return ((UPPER_HEX != 0) ? 8'h41 : 8'h61) + {4'h0, n} - 8'd10;
    endfunction

    assign bcd = dd[29:14];

    // Most significant non-zero time digit; a zero time still prints one digit.
    always_comb begin
        if (bcd[15:12] != 4'd0)     t_lead = 2'd3;
        else if (bcd[11:8] != 4'd0) t_lead = 2'd2;
        else if (bcd[7:4] != 4'd0)  t_lead = 2'd1;
        else                        t_lead = 2'd0;
    end

    always_comb begin
        grf_tens = 4'd0;
        grf_ones = 4'(grf_r);
        if (grf_r >= 5'd30) begin
            grf_tens = 4'd3;
            grf_ones = 4'(grf_r - 5'd30);
        end else if (grf_r >= 5'd20) begin
            grf_tens = 4'd2;
            grf_ones = 4'(grf_r - 5'd20);
        end else if (grf_r >= 5'd10) begin
            grf_tens = 4'd1;
            grf_ones = 4'(grf_r - 5'd10);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            idx        <= '0;
            cnt        <= '0;
            gap        <= '0;
            dd         <= '0;
            kind_r     <= 1'b0;
            pc_r       <= '0;
            grf_r      <= '0;
            addr_r     <= '0;
            data_r     <= '0;
            char       <= '0;
            char_valid <= 1'b0;
            last       <= 1'b0;
            in_ready   <= 1'b0;
            sat        <= 1'b0;
        end else begin
            char       <= '0;
            char_valid <= 1'b0;
            last       <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (in_ready && in_valid) begin
                        in_ready <= 1'b0;
                        kind_r   <= in_kind;
                        pc_r     <= in_pc;
                        grf_r    <= in_grf;
                        addr_r   <= in_addr;
                        data_r   <= in_data;
                        dd       <= {16'h0000, (in_time > 14'd9999) ? 14'd9999 : in_time};
                        cnt      <= '0;
                        if (in_time > 14'd9999)
                            sat <= 1'b1;
                        state    <= S_CONV;
                    end else if (gap != 4'd0) begin
                        gap      <= gap - 4'd1;
                        in_ready <= (gap == 4'd1);
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                S_CONV: begin
                    if (cnt != 4'd14) begin
                        dd  <= dd_step(dd);
                        cnt <= cnt + 4'd1;
                    end else begin
                        char       <= 8'h5e;
                        char_valid <= 1'b1;
                        idx        <= {1'b0, t_lead};
                        state      <= S_TIME;
                    end
                end
                S_TIME: begin
                    char       <= dec_char(bcd[{idx[1:0], 2'b00} +: 4]);
                    char_valid <= 1'b1;
                    if (idx == 3'd0) state <= S_AT;
                    else             idx   <= idx - 3'd1;
                end
                S_AT: begin
                    char       <= 8'h40;
                    char_valid <= 1'b1;
                    idx        <= 3'd7;
                    state      <= S_PC;
                end
                S_PC: begin
                    char       <= hex_char(pc_r[{idx, 2'b00} +: 4]);
                    char_valid <= 1'b1;
                    if (idx == 3'd0) begin
                        idx   <= 3'd1;
                        state <= S_SEP;
                    end else begin
                        idx <= idx - 3'd1;
                    end
                end
                S_SEP: begin
                    char       <= (idx == 3'd1) ? 8'h3a : 8'h20;
                    char_valid <= 1'b1;
                    if (idx == 3'd0) state <= S_SIGIL;
                    else             idx   <= idx - 3'd1;
                end
                S_SIGIL: begin
                    char       <= kind_r ? 8'h2a : 8'h24;
                    char_valid <= 1'b1;
                    if (kind_r) begin
                        idx   <= 3'd7;
                        state <= S_ADDR;
                    end else begin
                        idx   <= (grf_tens != 4'd0) ? 3'd1 : 3'd0;
                        state <= S_GRF;
                    end
                end
                S_GRF: begin
                    char       <= dec_char((idx == 3'd1) ? grf_tens : grf_ones);
                    char_valid <= 1'b1;
                    if (idx == 3'd0) begin
                        idx   <= 3'd3;
                        state <= S_ARROW;
                    end else begin
                        idx <= idx - 3'd1;
                    end
                end
                S_ADDR: begin
                    char       <= hex_char(addr_r[{idx, 2'b00} +: 4]);
                    char_valid <= 1'b1;
                    if (idx == 3'd0) begin
                        idx   <= 3'd3;
                        state <= S_ARROW;
                    end else begin
                        idx <= idx - 3'd1;
                    end
                end
                // Emits " <= " counting idx down from 3.
                S_ARROW: begin
                    case (idx)
                        3'd2:    char <= 8'h3c;
                        3'd1:    char <= 8'h3d;
                        default: char <= 8'h20;
                    endcase
                    char_valid <= 1'b1;
                    if (idx == 3'd0) begin
                        idx   <= 3'd7;
                        state <= S_DATA;
                    end else begin
                        idx <= idx - 3'd1;
                    end
                end
                S_DATA: begin
                    char       <= hex_char(data_r[{idx, 2'b00} +: 4]);
                    char_valid <= 1'b1;
                    if (idx == 3'd0) state <= S_HASH;
                    else             idx   <= idx - 3'd1;
                end
                S_HASH: begin
                    char       <= 8'h23;
                    char_valid <= 1'b1;
                    last       <= 1'b1;
                    state      <= S_END;
                end
                S_END: begin
                    gap      <= 4'(IDLE_GAP);
                    in_ready <= (IDLE_GAP == 0);
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_trace_emitter.sv
// Bench for cpu_trace_emitter: lane 0 uses lower-case hex and no idle gap,
// lane 1 upper-case hex with a two-cycle gap; a line-level model checks every cycle.
module tb_cpu_trace_emitter;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    logic        in_valid   [2];
    logic        in_ready   [2];
    logic        in_kind    [2];
    logic [13:0] in_time    [2];
    logic [31:0] in_pc      [2];
    logic [4:0]  in_grf     [2];
    logic [31:0] in_addr    [2];
    logic [31:0] in_data    [2];
    logic [7:0]  char_o     [2];
    logic        char_valid [2];
    logic        last       [2];
    logic        sat        [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_lane
        cpu_trace_emitter #(.UPPER_HEX(g), .IDLE_GAP(2 * g)) dut (
            .clk        (clk),
            .reset      (reset),
            .in_valid   (in_valid[g]),
            .in_ready   (in_ready[g]),
            .in_kind    (in_kind[g]),
            .in_time    (in_time[g]),
            .in_pc      (in_pc[g]),
            .in_grf     (in_grf[g]),
            .in_addr    (in_addr[g]),
            .in_data    (in_data[g]),
            .char       (char_o[g]),
            .char_valid (char_valid[g]),
            .last       (last[g]),
            .sat        (sat[g])
        );
    end

    // Model: each accepted record becomes 15 silent cycles, the formatted line,
    // then IDLE_GAP silent cycles; an empty schedule means ready.
    logic [8:0]  mq [2][$];
    logic        m_valid [2];
    logic [7:0]  m_char  [2];
    logic        m_ready [2];
    logic        m_sat   [2];
    int unsigned cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic string ref_line(int g, logic kind, logic [13:0] t, logic [31:0] pc,
                                       logic [4:0] grf, logic [31:0] addr, logic [31:0] data);
        int unsigned tv;
        string s;
        tv = (t > 14'd9999) ? 9999 : int'(t);
        if (kind) s = $sformatf("^%0d@%08x: *%08x <= %08x#", tv, pc, addr, data);
        else      s = $sformatf("^%0d@%08x: $%0d <= %08x#", tv, pc, grf, data);
        return (g == 1) ? s.toupper() : s;
    endfunction

    always @(posedge clk or negedge reset) begin
        string      s;
        logic [8:0] e;
        for (int g = 0; g < 2; g++) begin
            if (!reset) begin
                mq[g].delete();
                m_valid[g] = 1'b0;
                m_char[g]  = 8'h00;
                m_ready[g] = 1'b0;
                m_sat[g]   = 1'b0;
            end else begin
                if (m_ready[g] && in_valid[g]) begin
                    s = ref_line(g, in_kind[g], in_time[g], in_pc[g], in_grf[g], in_addr[g], in_data[g]);
                    repeat (15) mq[g].push_back(9'h000);
                    for (int i = 0; i < s.len(); i++) mq[g].push_back({1'b1, s[i]});
                    repeat (2 * g) mq[g].push_back(9'h000);
                    if (in_time[g] > 14'd9999) m_sat[g] = 1'b1;
                end
                if (mq[g].size() > 0) begin
                    e          = mq[g].pop_front();
                    m_valid[g] = e[8];
                    m_char[g]  = e[7:0];
                    m_ready[g] = 1'b0;
                end else begin
                    m_valid[g] = 1'b0;
                    m_char[g]  = 8'h00;
                    m_ready[g] = 1'b1;
                end
            end
        end
    end

    int          n_checks = 0;
    int          n_pass   = 0;
    string       cur_line  [2];
    string       last_line [2];
    int unsigned line_cnt  [2];
    int unsigned first_cyc [2];
    int unsigned hash_cyc  [2];
    int unsigned gap_meas  [2];
    int unsigned acc_cyc   [2];
    bit          have_hash [2];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic check_str(input string name, input string act, input string exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got \"%s\" expected \"%s\"", name, act, exp);
    endtask

    task automatic send(input int g, input logic kind, input logic [13:0] t, input logic [31:0] pc,
                        input logic [4:0] grf, input logic [31:0] addr, input logic [31:0] data,
                        input bit hold);
        int unsigned w = 0;
        in_kind[g]  = kind;
        in_time[g]  = t;
        in_pc[g]    = pc;
        in_grf[g]   = grf;
        in_addr[g]  = addr;
        in_data[g]  = data;
        in_valid[g] = 1'b1;
        while (!in_ready[g] && w < 400) begin
            @(negedge clk);
            w++;
        end
        if (w >= 400) begin
            n_checks++;
            $display("FAIL lane%0d accept: in_ready stayed 0, required 1 within 400 cycles", g);
            in_valid[g] = 1'b0;
            return;
        end
        @(posedge clk);
        #1 acc_cyc[g] = cyc;
        @(negedge clk);
        if (!hold) in_valid[g] = 1'b0;
    endtask

    task automatic wait_idle(input int g);
        int unsigned w = 0;
        while (!m_ready[g] && w < 400) begin
            @(negedge clk);
            w++;
        end
        if (w >= 400) begin
            n_checks++;
            $display("FAIL lane%0d idle: line still running after 400 cycles, required completion", g);
        end
    endtask

    task automatic stream(input int g);
        int unsigned n0;
        n0 = line_cnt[g];
        send(g, 1'b0, 14'd10,   32'h00000100, 5'd10, 32'h0,        32'h0000000a, 1'b1);
        send(g, 1'b1, 14'd123,  32'h00000104, 5'd0,  32'h00000200, 32'h0000000b, 1'b1);
        send(g, 1'b0, 14'd4321, 32'h00000108, 5'd9,  32'h0,        32'h0000000c, 1'b0);
        wait_idle(g);
        check($sformatf("lane%0d stream line count", g), 64'(line_cnt[g] - n0), 64'd3);
        check($sformatf("lane%0d stream gap '#' to '^'", g), 64'(gap_meas[g]), (g == 0) ? 64'd17 : 64'd19);
    endtask

    initial begin
        for (int g = 0; g < 2; g++) begin
            in_valid[g] = 1'b0; in_kind[g] = 1'b0; in_time[g] = '0; in_pc[g] = '0;
            in_grf[g] = '0; in_addr[g] = '0; in_data[g] = '0;
            m_valid[g] = 1'b0; m_char[g] = 8'h00; m_ready[g] = 1'b0; m_sat[g] = 1'b0;
            cur_line[g] = ""; last_line[g] = ""; line_cnt[g] = 0; have_hash[g] = 1'b0;
            first_cyc[g] = 0; hash_cyc[g] = 0; gap_meas[g] = 0; acc_cyc[g] = 0;
        end

        fork
            forever begin
                @(negedge clk);
                for (int g = 0; g < 2; g++) begin
                    check($sformatf("lane%0d cyc%0d {valid,char,last,ready,sat}", g, cyc),
                          64'({char_valid[g], char_o[g], last[g], in_ready[g], sat[g]}),
                          64'({m_valid[g], m_char[g], m_valid[g] && (m_char[g] == 8'h23), m_ready[g], m_sat[g]}));
                    if (!reset) begin
                        cur_line[g]  = "";
                        have_hash[g] = 1'b0;
                    end else if (char_valid[g]) begin
                        if (char_o[g] == 8'h5e) begin
                            cur_line[g]  = "";
                            first_cyc[g] = cyc;
                            if (have_hash[g]) gap_meas[g] = cyc - hash_cyc[g];
                        end
                        cur_line[g] = $sformatf("%s%c", cur_line[g], char_o[g]);
                        if (last[g]) begin
                            last_line[g] = cur_line[g];
                            line_cnt[g]++;
                            hash_cyc[g]  = cyc;
                            have_hash[g] = 1'b1;
                        end
                    end
                end
            end
        join_none

        // Reset held for three edges, released between edges.
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("lane0 in_ready after reset", 64'(in_ready[0]), 64'd1);
        check("lane1 in_ready after reset", 64'(in_ready[1]), 64'd1);

        // Register form, short fields.
        fork
            send(0, 1'b0, 14'd5, 32'h00003000, 5'd3, 32'hffffffff, 32'h00000001, 1'b0);
            send(1, 1'b0, 14'd5, 32'h00003000, 5'd3, 32'hffffffff, 32'h00000001, 1'b0);
        join
        fork wait_idle(0); wait_idle(1); join
        check_str("lane0 reg line", last_line[0], "^5@00003000: $3 <= 00000001#");
        check_str("lane1 reg line", last_line[1], "^5@00003000: $3 <= 00000001#");
        check("lane0 reg line length", 64'(last_line[0].len()), 64'd28);
        check("lane0 first-char latency", 64'(first_cyc[0] - acc_cyc[0]), 64'd15);
        check("lane1 first-char latency", 64'(first_cyc[1] - acc_cyc[1]), 64'd15);

        // Memory form, hex letters in both cases, in_grf ignored.
        fork
            send(0, 1'b1, 14'd9999, 32'h00003ffc, 5'd17, 32'h00002abc, 32'hdeadbeef, 1'b0);
            send(1, 1'b1, 14'd9999, 32'h00003ffc, 5'd17, 32'h00002abc, 32'hdeadbeef, 1'b0);
        join
        fork wait_idle(0); wait_idle(1); join
        check_str("lane0 mem line", last_line[0], "^9999@00003ffc: *00002abc <= deadbeef#");
        check_str("lane1 mem line", last_line[1], "^9999@00003FFC: *00002ABC <= DEADBEEF#");
        check("lane1 mem line length", 64'(last_line[1].len()), 64'd38);

        // Time 0, two-digit register, then saturation and stickiness.
        send(0, 1'b0, 14'd0, 32'h00000010, 5'd31, 32'h0, 32'h0000abcd, 1'b0);
        wait_idle(0);
        check_str("lane0 time0 grf31", last_line[0], "^0@00000010: $31 <= 0000abcd#");
        check("lane0 sat before overflow", 64'(sat[0]), 64'd0);
        send(0, 1'b0, 14'd12000, 32'h00000020, 5'd0, 32'h0, 32'h00000000, 1'b0);
        wait_idle(0);
        check_str("lane0 clamped time", last_line[0], "^9999@00000020: $0 <= 00000000#");
        check("lane0 sat after overflow", 64'(sat[0]), 64'd1);
        send(0, 1'b1, 14'd7, 32'h00000024, 5'd3, 32'h00000040, 32'h00000012, 1'b0);
        wait_idle(0);
        check_str("lane0 after overflow", last_line[0], "^7@00000024: *00000040 <= 00000012#");
        check("lane0 sat sticky", 64'(sat[0]), 64'd1);

        // Back-to-back records with in_valid held high.
        fork stream(0); stream(1); join
        check_str("lane0 stream last line", last_line[0], "^4321@00000108: $9 <= 0000000c#");
        check_str("lane1 stream last line", last_line[1], "^4321@00000108: $9 <= 0000000C#");

        // Reset while the tenth character is on the output.
        fork
            send(0, 1'b0, 14'd1234, 32'h12345678, 5'd9, 32'h0, 32'h00000055, 1'b0);
            send(1, 1'b0, 14'd1234, 32'h12345678, 5'd9, 32'h0, 32'h00000055, 1'b0);
        join
        repeat (24) @(posedge clk);
        #2;
        check("lane0 tenth char", 64'({char_valid[0], char_o[0]}), 64'h134);
        check("lane1 tenth char", 64'({char_valid[1], char_o[1]}), 64'h134);
        reset = 1'b0;
        #1;
        check("lane0 async drop", 64'({char_valid[0], char_o[0], last[0], in_ready[0], sat[0]}), 64'd0);
        check("lane1 async drop", 64'({char_valid[1], char_o[1], last[1], in_ready[1], sat[1]}), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        fork
            send(0, 1'b1, 14'd42, 32'h00000abc, 5'd0, 32'hcafe0000, 32'h00000001, 1'b0);
            send(1, 1'b1, 14'd42, 32'h00000abc, 5'd0, 32'hcafe0000, 32'h00000001, 1'b0);
        join
        fork wait_idle(0); wait_idle(1); join
        check_str("lane0 line after reset", last_line[0], "^42@00000abc: *cafe0000 <= 00000001#");
        check_str("lane1 line after reset", last_line[1], "^42@00000ABC: *CAFE0000 <= 00000001#");
        check("lane0 sat after reset", 64'(sat[0]), 64'd0);

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
